// File: rtl/vec_mag_seq.sv
// -----------------------------------------------------------------------------
// vec_mag_seq
//   Iterative vector-magnitude unit: mag = sqrt(x^2 + y^2) for unsigned W-bit
//   operands. Both squares are formed in parallel by W shift-add cycles. The
//   sum is then reduced by a restoring square root that resolves one result
//   bit (two radicand bits) per cycle over W+1 cycles. The result is floor or
//   round-to-nearest, selected by ROUND, and comes with a perfect-square flag.
//
// Parameters
//   W      operand width in bits (2..16)
//   ROUND  0 = floor(sqrt), 1 = round to nearest integer
//
// Ports
//   clk    in   1    system clock, rising edge
//   rst_n  in   1    asynchronous active-low reset
//   ena    in   1    global enable; when low all state holds (done still clears)
//   start  in   1    request, sampled only in IDLE with ena=1
//   x, y   in   W    unsigned operands, captured on start
//   busy   out  1    high from the start-capture edge until the done edge
//   done   out  1    one-cycle pulse; mag/exact valid from this cycle
//   mag    out  W+1  magnitude, held until the next done
//   exact  out  1    x^2+y^2 is a perfect square, held with mag
// -----------------------------------------------------------------------------
module vec_mag_seq #(
    parameter int W     = 8,
    parameter int ROUND = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W:0]   mag,
    output logic         exact
);

    localparam int PW = 2 * W;       // width of one square
    localparam int RW = 2 * W + 2;   // radicand / remainder / root working width
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_ROOT = 2'd2
    } state_t;

    // Round-to-nearest: after the floor root r, rem = sum - r^2, and
    // sum > r^2 + r  <=>  rem > r. Integer sums can never land on a tie.
    function automatic logic [W:0] round_mag(input logic [W:0]    root,
                                             input logic [RW-1:0] rem);
        logic up;
        up = (ROUND != 0) && (rem > RW'(root));
        return root + {{W{1'b0}}, up};
    endfunction

    state_t          state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [W-1:0]    x_q,      x_d;       // multiplier, shifted right each cycle
    logic [W-1:0]    y_q,      y_d;
    logic [PW-1:0]   x_sh_q,   x_sh_d;    // multiplicand, x << cnt
    logic [PW-1:0]   y_sh_q,   y_sh_d;
    logic [PW-1:0]   sum_x_q,  sum_x_d;
    logic [PW-1:0]   sum_y_q,  sum_y_d;
    logic [RW-1:0]   rem_q,    rem_d;
    logic [RW-1:0]   root_q,   root_d;
    logic [RW-1:0]   bit_q,    bit_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic [W:0]      mag_q,    mag_d;
    logic            exact_q,  exact_d;

    // One restoring-root step on the current registers.
    logic [RW-1:0]   trial;
    logic            take;
    logic [RW-1:0]   rem_n;
    logic [RW-1:0]   root_n;

    always_comb begin
        trial  = root_q + bit_q;
        take   = (rem_q >= trial);
        rem_n  = take ? (rem_q - trial) : rem_q;
        root_n = take ? ((root_q >> 1) + bit_q) : (root_q >> 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        x_sh_d  = x_sh_q;
        y_sh_d  = y_sh_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        rem_d   = rem_q;
        root_d  = root_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        mag_d   = mag_q;
        exact_d = exact_q;
        // done never stretches, even across a stall
        done_d  = 1'b0;

        if (ena) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_d     = x;
                        y_d     = y;
                        x_sh_d  = {{W{1'b0}}, x};
                        y_sh_d  = {{W{1'b0}}, y};
                        sum_x_d = '0;
                        sum_y_d = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_SQR;
                    end
                end

                S_SQR: begin
                    if (cnt_q == CW'(W)) begin
                        // All partial products are in; load the root datapath.
                        rem_d   = RW'(sum_x_q) + RW'(sum_y_q);
                        root_d  = '0;
                        bit_d   = RW'(1) << (2 * W);
                        cnt_d   = '0;
                        state_d = S_ROOT;
                    end else begin
                        sum_x_d = sum_x_q + (x_q[0] ? x_sh_q : '0);
                        sum_y_d = sum_y_q + (y_q[0] ? y_sh_q : '0);
                        x_d     = x_q >> 1;
                        y_d     = y_q >> 1;
                        x_sh_d  = x_sh_q << 1;
                        y_sh_d  = y_sh_q << 1;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end

                S_ROOT: begin
                    rem_d  = rem_n;
                    root_d = root_n;
                    bit_d  = bit_q >> 2;
                    if (cnt_q == CW'(W)) begin
                        // Final step: root_n is floor(sqrt(sum)) and fits W+1 bits.
                        mag_d   = round_mag(root_n[W:0], rem_n);
                        exact_d = (rem_n == '0);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x_sh_q  <= '0;
            y_sh_q  <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mag_q   <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mag_q   <= mag_d;
            exact_q <= exact_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign mag   = mag_q;
    assign exact = exact_q;

endmodule

// File: tb/tb_vec_mag_seq.sv
// -----------------------------------------------------------------------------
// tb_vec_mag_seq
//   Three instances: W=8 floor and W=8 round share one stimulus set; a W=4
//   round instance has its own. Expected results come from an integer
//   linear-search square root and are queued with their due cycle when the
//   start is captured; monitors pop and compare whenever done is seen.
// -----------------------------------------------------------------------------
module tb_vec_mag_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       ena8 = 1'b1, start8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       busy0, done0, exact0;
    logic [8:0] mag0;
    logic       busy1, done1, exact1;
    logic [8:0] mag1;

    logic       ena4 = 1'b1, start4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       busy2, done2, exact2;
    logic [4:0] mag2;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        longint mag;
        bit     exact;
        longint due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    vec_mag_seq #(.W(8), .ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .start(start8), .x(x8), .y(y8),
        .busy(busy0), .done(done0), .mag(mag0), .exact(exact0));

    vec_mag_seq #(.W(8), .ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .start(start8), .x(x8), .y(y8),
        .busy(busy1), .done(done1), .mag(mag1), .exact(exact1));

    vec_mag_seq #(.W(4), .ROUND(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .start(start4), .x(x4), .y(y4),
        .busy(busy2), .done(done2), .mag(mag2), .exact(exact2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: smallest-r linear search, independent of the digit recurrence.
    function automatic exp_t model(input longint xa, input longint ya,
                                   input bit rnd, input longint due);
        exp_t   e;
        longint s, r;
        s = xa * xa + ya * ya;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        e.exact = (r * r == s);
        e.mag   = r + ((rnd && (s - r * r) > r) ? 1 : 0);
        e.due   = due;
        return e;
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) check_val("dut0_spurious_done", 1, 0);
            else begin
                exp_t e;
                e = q0.pop_front();
                check_val("dut0_mag", mag0, e.mag);
                check_val("dut0_exact", exact0, e.exact);
                check_val("dut0_latency", cyc, e.due);
            end
        end
        if (done1) begin
            if (q1.size() == 0) check_val("dut1_spurious_done", 1, 0);
            else begin
                exp_t e;
                e = q1.pop_front();
                check_val("dut1_mag", mag1, e.mag);
                check_val("dut1_exact", exact1, e.exact);
                check_val("dut1_latency", cyc, e.due);
            end
        end
        if (done2) begin
            if (q2.size() == 0) check_val("dut2_spurious_done", 1, 0);
            else begin
                exp_t e;
                e = q2.pop_front();
                check_val("dut2_mag", mag2, e.mag);
                check_val("dut2_exact", exact2, e.exact);
                check_val("dut2_latency", cyc, e.due);
            end
        end
    end

    // Called at a negedge. Captures on the next posedge; extra = stalled edges.
    task automatic op8(input logic [7:0] xa, input logic [7:0] ya,
                       input bit push, input int extra);
        x8 = xa;
        y8 = ya;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            q0.push_back(model(xa, ya, 1'b0, cyc + 18 + extra));
            q1.push_back(model(xa, ya, 1'b1, cyc + 18 + extra));
        end
        start8 = 1'b0;
        x8 = ~xa;
        y8 = ~ya;
        check_val("busy8_rise", busy0, 1);
    endtask

    task automatic op4(input logic [3:0] xa, input logic [3:0] ya);
        x4 = xa;
        y4 = ya;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        q2.push_back(model(xa, ya, 1'b1, cyc + 10));
        start4 = 1'b0;
        x4 = ~xa;
        y4 = ~ya;
        check_val("busy4_rise", busy2, 1);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(input int which);
        int n;
        n = 0;
        while (((which == 0) ? done0 : done2) !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check_val("done_timeout", 0, 1);
        else check_val("busy_at_done", (which == 0) ? busy0 : busy2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy0, 0);
        check_val("rst_done", done0, 0);
        check_val("rst_mag", mag0, 0);
        check_val("rst_exact", exact0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // W=4 rounding cases
        op4(4'd15, 4'd15); wait_done(2);
        @(negedge clk); op4(4'd1, 4'd2);  wait_done(2);
        @(negedge clk); op4(4'd0, 4'd0);  wait_done(2);
        @(negedge clk); op4(4'd15, 4'd0); wait_done(2);
        @(negedge clk); op4(4'd5, 4'd12); wait_done(2);

        // W=8 directed and random operands
        @(negedge clk); op8(8'd3, 8'd4, 1'b1, 0);
        repeat (9) @(negedge clk);
        check_val("busy8_mid", busy0, 1);
        wait_done(0);
        @(negedge clk); op8(8'd255, 8'd255, 1'b1, 0); wait_done(0);
        @(negedge clk); op8(8'd0, 8'd0, 1'b1, 0);     wait_done(0);
        @(negedge clk); op8(8'd1, 8'd1, 1'b1, 0);     wait_done(0);
        @(negedge clk); op8(8'd255, 8'd0, 1'b1, 0);   wait_done(0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 0);
            wait_done(0);
        end

        // start again at edge 5 of an op must be ignored
        @(negedge clk); op8(8'd20, 8'd21, 1'b1, 0);
        repeat (5) @(negedge clk);
        start8 = 1'b1; x8 = 8'd9; y8 = 8'd9;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0);

        // back-to-back: new start during the done cycle
        op8(8'd100, 8'd200, 1'b1, 0);
        wait_done(0);
        repeat (3) @(negedge clk);

        // 3-cycle stall in the middle of ROOT
        op8(8'd33, 8'd56, 1'b1, 3);
        repeat (13) @(negedge clk);
        ena8 = 1'b0;
        repeat (3) @(negedge clk);
        ena8 = 1'b1;
        wait_done(0);

        // reset in the middle of SQR aborts with no done
        @(negedge clk); op8(8'd7, 8'd9, 1'b0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", busy0, 0);
        check_val("abort_mag", mag0, 0);
        check_val("abort_exact", exact0, 0);
        check_val("abort_done", done0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        op8(8'd6, 8'd8, 1'b1, 0); wait_done(0);

        repeat (5) @(negedge clk);
        check_val("q0_drained", q0.size(), 0);
        check_val("q1_drained", q1.size(), 0);
        check_val("q2_drained", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
